// File: rtl/stream_demux_reg.sv
// stream_demux_reg: registered 1-to-NUM_CH valid/ready demux, one holding slot per channel.
// Optional broadcast input enabled by defining STREAM_DEMUX_BROADCAST_EN.
module stream_demux_reg #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        din,
  input  logic [SEL_W-1:0]         sel,
`ifdef STREAM_DEMUX_BROADCAST_EN
  input  logic                     bcast,
`endif
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [7:0]               drop_cnt
);

  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [7:0]               drop_q, drop_d;

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] load;
  logic              in_range;
  logic              bc;
  logic              fire;
  logic              drop;

`ifdef STREAM_DEMUX_BROADCAST_EN
  assign bc = bcast;
`else
  assign bc = 1'b0;
`endif

  // One-hot decode of sel; an out-of-range sel leaves hit all zero.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = (sel == SEL_W'(i));
    end
  end

  assign in_range  = |hit;
  assign slot_free = ~valid_q | out_ready;

  // Ready depends only on the addressed slot(s); dropped words are always taken.
  always_comb begin
    in_ready = 1'b1;
    if (bc) begin
      in_ready = &slot_free;
    end else if (in_range) begin
      in_ready = |(hit & slot_free);
    end
  end

  assign fire = in_valid & in_ready;
  assign drop = fire & ~bc & ~in_range;

  // Per-slot load enables; broadcast loads every slot in the same edge.
  always_comb begin
    load = '0;
    if (fire) begin
      load = bc ? {NUM_CH{1'b1}} : hit;
    end
  end

  // Slot next state: load wins, otherwise a drain empties the slot.
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) begin
        data_d[i*DATA_W +: DATA_W] = din;
      end
    end
  end

  // Saturating count of discarded out-of-range words.
  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers; reset clears slots, payloads and the drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
// tb_stream_demux_reg: scoreboard bench for stream_demux_reg with NUM_CH=5.
// Broadcast phase runs only when STREAM_DEMUX_BROADCAST_EN is defined.
module tb_stream_demux_reg;
  localparam int DW  = 8;
  localparam int NCH = 5;
  localparam int SW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     din;
  logic [SW-1:0]     sel;
  logic              bcast;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] dout;
  logic [7:0]        drop_cnt;

  stream_demux_reg #(.DATA_W(DW), .NUM_CH(NCH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .sel      (sel),
`ifdef STREAM_DEMUX_BROADCAST_EN
    .bcast    (bcast),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  logic [DW-1:0] expq [NCH][$];
  logic [DW-1:0] last_v [NCH];
  int            exp_drop = 0;
  int            ndrain [NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      last_v[c] = '0;
      ndrain[c] = 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  // Reference acceptance rule: the addressed slot(s) must be empty or draining.
  function automatic bit model_ready();
    bit r;
    r = 1'b1;
    if (bcast) begin
      for (int c = 0; c < NCH; c++)
        if (expq[c].size() != 0 && !out_ready[c]) r = 1'b0;
    end else if (int'(sel) < NCH) begin
      r = (expq[sel].size() == 0) || out_ready[sel];
    end
    return r;
  endfunction

  // Predictor: accepted words are pushed as expected channel outputs.
  always @(posedge clk) begin
    if (!rst && in_valid && model_ready()) begin
      if (bcast) begin
        for (int c = 0; c < NCH; c++) begin
          expq[c].push_back(din);
          last_v[c] = din;
        end
      end else if (int'(sel) < NCH) begin
        expq[sel].push_back(din);
        last_v[sel] = din;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  end

  // Consumer side: a handshake retires the oldest expected word.
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (expq[c].size() != 0 && out_ready[c]) begin
          void'(expq[c].pop_front());
          ndrain[c]++;
        end
      end
    end
  end

  // Monitor: compare presented outputs with the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]),
            64'(expq[c].size() != 0));
        if (expq[c].size() != 0)
          chk($sformatf("dout[%0d]", c), 64'(dout[c*DW +: DW]),
              64'(expq[c][0]));
        else
          chk($sformatf("dout_hold[%0d]", c), 64'(dout[c*DW +: DW]),
              64'(last_v[c]));
      end
      chk("in_ready", 64'(in_ready), 64'(model_ready()));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    bcast     = 1'b0;
    out_ready = '1;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int base;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; din = '0; sel = '0;
    out_ready = '0; bcast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    for (int c = 0; c < NCH; c++)
      chk("rst_dout", 64'(dout[c*DW +: DW]), 64'(0));

    // Routing and stall on a full channel
    in_valid = 1'b1; din = 8'hA5; sel = 2; out_ready = '0;
    step();
    in_valid = 1'b0;
    #1;
    chk("route_valid", 64'(out_valid), 64'(5'b00100));
    chk("route_dout", 64'(dout[23:16]), 64'(8'hA5));
    in_valid = 1'b1; din = 8'h11; sel = 2;
    #1 chk("stall_ready", 64'(in_ready), 64'(0));
    step();
    chk("stall_ready2", 64'(in_ready), 64'(0));
    out_ready = 5'b00100;
    #1 chk("unstall_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; out_ready = '0;
    #1;
    chk("reload_valid", 64'(out_valid), 64'(5'b00100));
    chk("reload_dout", 64'(dout[23:16]), 64'(8'h11));
    drain_all();

    // Throughput on channel 0
    base = ndrain[0];
    out_ready = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; din = DW'(k); sel = 0;
      #1 chk("thru_ready", 64'(in_ready), 64'(1));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("thru_count", 64'(ndrain[0] - base), 64'(8));
    drain_all();

    // Isolation: channel 1 stalled and full
    out_ready = '0;
    in_valid = 1'b1; sel = 1; din = 8'h77;
    step();
    out_ready = 5'b11101;
    for (int k = 0; k < 6; k++) begin
      sel = (k % 2) ? 3 : 0;
      din = DW'($urandom);
      #1 chk("iso_ready", 64'(in_ready), 64'(1));
      step();
    end
    sel = 1; din = 8'h88;
    #1 chk("iso_block", 64'(in_ready), 64'(0));
    step();
    chk("iso_block2", 64'(in_ready), 64'(0));
    out_ready = '1;
    #1 chk("iso_release", 64'(in_ready), 64'(1));
    step();
    drain_all();

    // Out-of-range selects saturate the drop counter
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'b1;
      sel = SW'(NCH + $urandom_range(0, (1 << SW) - NCH - 1));
      din = DW'($urandom);
      out_ready = NCH'($urandom);
      #1;
      chk("oor_ready", 64'(in_ready), 64'(1));
      chk("oor_valid", 64'(out_valid), 64'(0));
      step();
    end
    in_valid = 1'b0;
    #1 chk("oor_sat", 64'(drop_cnt), 64'(255));

    // Asynchronous reset mid-stream with channels 1 and 3 full
    out_ready = '0;
    in_valid = 1'b1; sel = 1; din = 8'h5E;
    step();
    sel = 3; din = 8'hC3;
    step();
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", 64'(out_valid), 64'(5'b01010));
    #2 rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      expq[c].delete();
      last_v[c] = '0;
    end
    exp_drop = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_drop", 64'(drop_cnt), 64'(0));
    for (int c = 0; c < NCH; c++)
      chk("mid_rst_dout", 64'(dout[c*DW +: DW]), 64'(0));
    step();
    rst = 1'b0;
    step();

`ifdef STREAM_DEMUX_BROADCAST_EN
    // Broadcast into empty slots, then stall on one full slot
    out_ready = '0;
    bcast = 1'b1; in_valid = 1'b1; din = 8'h3C; sel = 1;
    #1 chk("bc_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; bcast = 1'b0;
    #1;
    chk("bc_valid", 64'(out_valid), 64'({NCH{1'b1}}));
    for (int c = 0; c < NCH; c++)
      chk("bc_dout", 64'(dout[c*DW +: DW]), 64'(8'h3C));
    out_ready = 5'b11011;
    bcast = 1'b1; in_valid = 1'b1; din = 8'h5A;
    #1 chk("bc_block", 64'(in_ready), 64'(0));
    step();
    chk("bc_block2", 64'(in_ready), 64'(0));
    out_ready = '1;
    #1 chk("bc_release", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; bcast = 1'b0; out_ready = '0;
    #1;
    for (int c = 0; c < NCH; c++)
      chk("bc_dout2", 64'(dout[c*DW +: DW]), 64'(8'h5A));
    drain_all();
`endif

    // Randomised traffic; producer holds din/sel until accepted
    in_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel = SW'($urandom);
        din = DW'($urandom);
`ifdef STREAM_DEMUX_BROADCAST_EN
        bcast = ($urandom_range(0, 7) == 0);
`endif
      end
      out_ready = NCH'($urandom);
    end
    in_valid = 1'b0;
    bcast = 1'b0;
    drain_all();
    chk("final_valid", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
